// File: rtl/serializator_param_if.sv
// rtl/serializator_param_if.sv - parallel word in / serial bit out bundle for serializator_param
interface serializator_param_if #(
    parameter int DATA_W = 16,
    localparam int MOD_W = $clog2(DATA_W)
);
    logic [DATA_W-1:0] data_i;
    logic [MOD_W-1:0]  data_mod_i;
    logic              data_val_i;
    logic              lsb_first_i;
    logic              ser_data_o;
    logic              ser_data_val_o;
    logic              ser_last_o;
    logic              busy_o;
    logic              drop_o;

    // word source / serial sink side
    modport master (
        output data_i, data_mod_i, data_val_i, lsb_first_i,
        input  ser_data_o, ser_data_val_o, ser_last_o, busy_o, drop_o
    );

    // serializer side
    modport slave (
        input  data_i, data_mod_i, data_val_i, lsb_first_i,
        output ser_data_o, ser_data_val_o, ser_last_o, busy_o, drop_o
    );
endinterface

// File: rtl/serializator_param.sv
// rtl/serializator_param.sv - variable-length parallel-to-serial converter with one-word pending buffer
module serializator_param #(
    parameter int DATA_W  = 16,
    parameter int MIN_LEN = 3,
    localparam int MOD_W  = $clog2(DATA_W)
) (
    input  logic               clk_i,
    input  logic               arst_i,
    serializator_param_if.slave bus
);
    localparam int CW = MOD_W + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [DATA_W-1:0] sh_data;
    logic              sh_lsb;
    logic [CW-1:0]     cnt;       // bits still to emit, including the current one
    logic [DATA_W-1:0] buf_data;
    logic              buf_lsb;
    logic [CW-1:0]     buf_len;
    logic              buf_full;
    logic              drop_q;

    logic [CW-1:0]     in_len;
    logic              take;
    logic              legal;
    logic              accept;
    logic              last_bit;

    // frame length: a zero length field stands for a full word
    assign in_len   = (bus.data_mod_i == '0) ? CW'(DATA_W) : {1'b0, bus.data_mod_i};
    assign take     = bus.data_val_i & ~buf_full;
    assign legal    = (in_len >= CW'(MIN_LEN));
    assign accept   = take & legal;
    assign last_bit = (state == SHIFT) && (cnt == CW'(1));

    // shifter, pending buffer and frame FSM
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            sh_data  <= '0;
            sh_lsb   <= 1'b0;
            cnt      <= '0;
            buf_data <= '0;
            buf_lsb  <= 1'b0;
            buf_len  <= '0;
            buf_full <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= take & ~legal;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_data <= bus.data_i;
                        sh_lsb  <= bus.lsb_first_i;
                        cnt     <= in_len;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        // buffer has priority; it can only be full when no new word is taken
                        if (buf_full) begin
                            sh_data  <= buf_data;
                            sh_lsb   <= buf_lsb;
                            cnt      <= buf_len;
                            buf_full <= 1'b0;
                        end else if (accept) begin
                            sh_data <= bus.data_i;
                            sh_lsb  <= bus.lsb_first_i;
                            cnt     <= in_len;
                        end else begin
                            sh_data <= '0;
                            cnt     <= '0;
                            state   <= IDLE;
                        end
                    end else begin
                        sh_data <= sh_lsb ? (sh_data >> 1) : (sh_data << 1);
                        cnt     <= cnt - CW'(1);
                        if (accept) begin
                            buf_data <= bus.data_i;
                            buf_lsb  <= bus.lsb_first_i;
                            buf_len  <= in_len;
                            buf_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // outputs come straight from registers; the current bit sits at the shifter's exit end
    assign bus.ser_data_val_o = (state == SHIFT);
    assign bus.ser_data_o     = (state == SHIFT) & (sh_lsb ? sh_data[0] : sh_data[DATA_W-1]);
    assign bus.ser_last_o     = last_bit;
    assign bus.busy_o         = buf_full;
    assign bus.drop_o         = drop_q;
endmodule

// File: tb/tb_serializator_param.sv
// tb/tb_serializator_param.sv - self-checking bench for serializator_param
module tb_serializator_param;
    localparam int DATA_W  = 16;
    localparam int MIN_LEN = 3;
    localparam int MAXC    = 4096;

    logic clk  = 1'b0;
    logic arst = 1'b1;

    serializator_param_if #(.DATA_W(DATA_W)) io();

    serializator_param #(.DATA_W(DATA_W), .MIN_LEN(MIN_LEN)) dut (
        .clk_i (clk),
        .arst_i(arst),
        .bus   (io.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // cycle-level schedule of what the output must show; cycle c follows rising edge c
    int cyc = 0;
    bit ev[MAXC];
    bit eb[MAXC];
    bit el[MAXC];
    bit ed[MAXC];
    int last_end   = -1;
    bit pend       = 0;
    int pend_start = 0;
    bit taken      = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        logic        lsb;
        int          len;
        logic [15:0] seq;   // seq[15-i] is the i-th emitted bit
        logic        drop;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_busy(input int c);
        return pend && (pend_start > c);
    endfunction

    // decide the fate of the presented word, advance one clock, then check every output
    task automatic tick();
        int e;
        int l;
        int start;
        e = cyc + 1;
        taken = 0;
        if (io.data_val_i && !m_busy(cyc)) begin
            taken = 1;
            l = (io.data_mod_i == 0) ? DATA_W : int'(io.data_mod_i);
            if (l < MIN_LEN) begin
                ed[e] = 1;
            end else begin
                start = (last_end + 1 > e) ? last_end + 1 : e;
                if (start + l < MAXC) begin
                    for (int i = 0; i < l; i++) begin
                        ev[start+i] = 1;
                        eb[start+i] = io.lsb_first_i ? io.data_i[i] : io.data_i[DATA_W-1-i];
                    end
                    el[start+l-1] = 1;
                end
                last_end = start + l - 1;
                if (start > e) begin
                    pend       = 1;
                    pend_start = start;
                end
            end
        end
        @(posedge clk);
        cyc = e;
        if (pend && pend_start <= cyc) pend = 0;
        @(negedge clk);
        chk("ser_data_val", io.ser_data_val_o, ev[cyc]);
        chk("ser_data",     io.ser_data_o,     eb[cyc]);
        chk("ser_last",     io.ser_last_o,     el[cyc]);
        chk("busy",         io.busy_o,         m_busy(cyc));
        chk("drop",         io.drop_o,         ed[cyc]);
    endtask

    task automatic model_reset();
        for (int c = cyc + 1; c < MAXC; c++) begin
            ev[c] = 0; eb[c] = 0; el[c] = 0; ed[c] = 0;
        end
        last_end = cyc;
        pend     = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_val"},  io.ser_data_val_o, 1'b0);
        chk({tag, "_data"}, io.ser_data_o,     1'b0);
        chk({tag, "_last"}, io.ser_last_o,     1'b0);
        chk({tag, "_busy"}, io.busy_o,         1'b0);
        chk({tag, "_drop"}, io.drop_o,         1'b0);
    endtask

    task automatic present(input logic [15:0] d, input logic [3:0] m, input logic lsb);
        io.data_i      = d;
        io.data_mod_i  = m;
        io.lsb_first_i = lsb;
        io.data_val_i  = 1'b1;
    endtask

    initial begin
        vecs[0] = '{16'hB000, 4'd6, 1'b0,  6, 16'b1011_0000_0000_0000, 1'b0};
        vecs[1] = '{16'hB005, 4'd0, 1'b1, 16, 16'b1010_0000_0000_1101, 1'b0};
        vecs[2] = '{16'h0001, 4'd1, 1'b0,  0, 16'h0000,                1'b1};
        vecs[3] = '{16'hFFFF, 4'd2, 1'b1,  0, 16'h0000,                1'b1};
        vecs[4] = '{16'h8001, 4'd3, 1'b1,  3, 16'b1000_0000_0000_0000, 1'b0};
        vecs[5] = '{16'hF0F0, 4'd0, 1'b0, 16, 16'hF0F0,                1'b0};

        io.data_i = '0; io.data_mod_i = '0; io.data_val_i = 1'b0; io.lsb_first_i = 1'b0;

        // reset state, with a valid word already presented
        present(16'hFFFF, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        io.data_val_i = 1'b0;
        arst = 1'b0;

        // directed table vectors, each applied from idle
        for (int v = 0; v < 6; v++) begin
            present(vecs[v].data, vecs[v].mod, vecs[v].lsb);
            tick();
            io.data_val_i = 1'b0;
            if (vecs[v].drop) begin
                chk("vec_drop", io.drop_o, 1'b1);
                chk("vec_drop_val", io.ser_data_val_o, 1'b0);
                chk("vec_drop_busy", io.busy_o, 1'b0);
                tick();
                chk("vec_drop_pulse", io.drop_o, 1'b0);
            end else begin
                for (int i = 0; i < vecs[v].len; i++) begin
                    chk("vec_val", io.ser_data_val_o, 1'b1);
                    chk("vec_bit", io.ser_data_o, vecs[v].seq[15-i]);
                    chk("vec_last", io.ser_last_o, i == vecs[v].len - 1);
                    tick();
                end
                chk("vec_idle", io.ser_data_val_o, 1'b0);
            end
        end
        repeat (2) tick();

        // back-to-back: A (1,0,1,0), B buffered (0,1,1), C ignored while busy
        present(16'hA000, 4'd4, 1'b0);
        tick();
        present(16'h0006, 4'd3, 1'b1);
        tick();
        chk("b2b_busy_set", io.busy_o, 1'b1);
        present(16'hFFFF, 4'd0, 1'b0);
        tick();
        tick();
        chk("b2b_a_last", io.ser_last_o, 1'b1);
        chk("b2b_busy_hold", io.busy_o, 1'b1);
        tick();
        io.data_val_i = 1'b0;
        chk("b2b_busy_fall", io.busy_o, 1'b0);
        chk("b2b_b_first_val", io.ser_data_val_o, 1'b1);
        chk("b2b_b_first_bit", io.ser_data_o, 1'b0);
        tick();
        chk("b2b_b_bit1", io.ser_data_o, 1'b1);
        tick();
        chk("b2b_b_last", io.ser_last_o, 1'b1);
        tick();
        chk("b2b_c_ignored", io.ser_data_val_o, 1'b0);
        repeat (2) tick();

        // randomized traffic against the schedule model; the source holds ignored words
        io.data_val_i = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!io.data_val_i || taken) begin
                if ($urandom_range(0, 1) == 1)
                    present(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                else
                    io.data_val_i = 1'b0;
            end
            tick();
        end
        io.data_val_i = 1'b0;
        repeat (40) tick();

        // reset during bit 5 of a full-width frame with a word buffered
        present(16'hC3A5, 4'd0, 1'b0);
        tick();
        present(16'h5555, 4'd5, 1'b1);
        tick();
        chk("rst_pre_busy", io.busy_o, 1'b1);
        io.data_val_i = 1'b0;
        repeat (3) tick();
        chk("rst_pre_val", io.ser_data_val_o, 1'b1);
        arst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst_hold");
        model_reset();
        arst = 1'b0;
        // first edge after release must accept
        present(16'h9C00, 4'd7, 1'b0);
        tick();
        io.data_val_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("post_rst_val", io.ser_data_val_o, 1'b1);
            chk("post_rst_bit", io.ser_data_o, (i == 0 || i == 3 || i == 4 || i == 5));
            tick();
        end
        chk("post_rst_idle", io.ser_data_val_o, 1'b0);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
